// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the data-cache line controller
// Purpose: controller state encoding, burst step constant and line-offset helper.
// Ports: none (package).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_STEP_ONE = 2'd1;

  // Byte-offset bits inside a line of 32-bit words.
  function automatic int line_off_w(input int words);
    return $clog2(words) + 2;
  endfunction

  // Value for the default 8-word line; the top recomputes it from its own parameter.
  localparam int LINE_OFF_W = line_off_w(8);

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - line-wide word buffer with parallel load and indexed access
// Purpose: WORDS x 32-bit register array holding one cache line.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears all words)
//   i_load/i_load_line parallel load of the whole line (word 0 in bits [31:0])
//   i_wr_en/i_wr_idx/i_wr_data  single-word write
//   i_rd_idx/o_rd_data          combinational single-word read
//   o_line                      whole line, flat
module line_buf #(
  parameter int WORDS = 8,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WORDS*32-1:0]   i_load_line,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic [31:0]           o_rd_data,
  output logic [WORDS*32-1:0]   o_line
);

  logic [31:0] r_mem [WORDS];

  // A parallel load wins over a single-word write in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= i_load_line[i*32 +: 32];
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];

  always_comb begin
    o_line = '0;
    for (int i = 0; i < WORDS; i++) o_line[i*32 +: 32] = r_mem[i];
  end

endmodule

// File: rtl/dcache_line_ctrl.sv
// rtl/dcache_line_ctrl.sv - data-cache line refill / dirty write-back controller
// Purpose: accepts one miss at a time, optionally writes the dirty victim as an
//   INCR burst, fetches the missing line as an INCR burst and returns it as a
//   one-cycle refill pulse.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   miss_req/miss_addr/miss_ready       miss handshake (accepted only in IDLE)
//   victim_dirty/victim_addr/victim_line victim line captured at acceptance
//   refill_valid/refill_line            refilled line, valid for one cycle
//   axi_aw_en/axi_ar_en                 level burst requests to the bus interface
//   cpu_wr_addr/cpu_rd_addr             line-aligned burst addresses
//   cpu_wr_data                         current write-beat word
//   aw/ar_burst_len, aw/ar_burst_step   constant burst shape
//   bus_wr_data_ready/bus_wr_data_finish write beat accepted / burst complete
//   bus_rd_data_ready/cpu_rd_data       read beat strobe and data
module dcache_line_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_req,
  input  logic [ADDR_W-1:0]          miss_addr,
  input  logic                       victim_dirty,
  input  logic [ADDR_W-1:0]          victim_addr,
  input  logic [LINE_WORDS*32-1:0]   victim_line,
  output logic                       miss_ready,
  output logic                       refill_valid,
  output logic [LINE_WORDS*32-1:0]   refill_line,
  output logic                       axi_aw_en,
  output logic                       axi_ar_en,
  output logic [31:0]                cpu_wr_addr,
  output logic [31:0]                cpu_rd_addr,
  output logic [31:0]                cpu_wr_data,
  output logic [7:0]                 aw_burst_len,
  output logic [7:0]                 ar_burst_len,
  output logic [1:0]                 aw_burst_step,
  output logic [1:0]                 ar_burst_step,
  input  logic                       bus_wr_data_ready,
  input  logic                       bus_wr_data_finish,
  input  logic                       bus_rd_data_ready,
  input  logic [31:0]                cpu_rd_data
);

  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int OFF_W  = line_off_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [IDX_W-1:0]  WR_LAST   = (IDX_W)'(LINE_WORDS - 1);
  localparam logic [IDX_W:0]    RD_LAST   = (IDX_W+1)'(LINE_WORDS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_rd_addr;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [IDX_W-1:0]     r_wr_idx;
  // One spare bit so the index can count a full line; DONE is taken on the
  // last strobe, so it never actually wraps inside a burst.
  logic [IDX_W:0]       r_rd_idx;
  logic                 w_accept;
  logic                 w_wr_beat;
  logic                 w_rd_beat;

  logic [LINE_WORDS*32-1:0] w_wb_line_unused;
  logic [31:0]              w_rd_word_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Enables and handshakes are decoded purely from the registered state, so
  // each enable is held for its whole state and drops for DONE and IDLE
  // between transactions.
  always_comb begin
    w_next       = r_state;
    miss_ready   = 1'b0;
    axi_aw_en    = 1'b0;
    axi_ar_en    = 1'b0;
    refill_valid = 1'b0;
    case (r_state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) w_next = victim_dirty ? WB : RD;
      end
      WB: begin
        axi_aw_en = 1'b1;
        if (bus_wr_data_finish) w_next = RD;
      end
      RD: begin
        axi_ar_en = 1'b1;
        if (bus_rd_data_ready && (r_rd_idx == RD_LAST)) w_next = DONE;
      end
      DONE: begin
        refill_valid = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && miss_req;
  assign w_wr_beat = (r_state == WB) && bus_wr_data_ready;
  assign w_rd_beat = (r_state == RD) && bus_rd_data_ready;

  // Addresses are only written at acceptance, keeping them stable for the
  // interface, which samples them one edge after the enable rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
    end else if (w_accept) begin
      r_rd_addr <= miss_addr & LINE_MASK;
      r_wr_addr <= victim_addr & LINE_MASK;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
    end else begin
      if (w_wr_beat && (r_wr_idx != WR_LAST)) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_rd_beat) r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  line_buf #(.WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_wb_buf (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_accept),
    .i_load_line (victim_line),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_data   (32'd0),
    .i_rd_idx    (r_wr_idx),
    .o_rd_data   (cpu_wr_data),
    .o_line      (w_wb_line_unused)
  );

  line_buf #(.WORDS(LINE_WORDS), .IDX_W(IDX_W)) u_rd_buf (
    .clk         (clk),
    .rst         (reset),
    .i_load      (1'b0),
    .i_load_line ('0),
    .i_wr_en     (w_rd_beat),
    .i_wr_idx    (r_rd_idx[IDX_W-1:0]),
    .i_wr_data   (cpu_rd_data),
    .i_rd_idx    ('0),
    .o_rd_data   (w_rd_word_unused),
    .o_line      (refill_line)
  );

  assign cpu_rd_addr   = 32'(r_rd_addr);
  assign cpu_wr_addr   = 32'(r_wr_addr);
  assign aw_burst_len  = 8'(LINE_WORDS - 1);
  assign ar_burst_len  = 8'(LINE_WORDS - 1);
  assign aw_burst_step = AXI_BURST_STEP_ONE;
  assign ar_burst_step = AXI_BURST_STEP_ONE;

endmodule
